dcache_flush_ctrl: RTL and testbench

- Memory-side line refill/writeback engine for the data cache; sits between the cache lines/queue and the memory controller.
- On a miss it takes a victim line, writes it back if dirty, then burst-fills it with the new line.
- During the fill it forwards the word a pending CPU read is waiting for.
- Drives the lines' flush_mode/flush_we/flush_addr/flush_in interface.

---
 rtl/dcache_flush_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_ctrl.sv
// Data cache refill/writeback engine: evicts a victim line (writing it back
// when dirty), burst-fills the new contents and forwards the word a pending
// CPU read is waiting for.
module dcache_flush_ctrl #(
    parameter int unsigned DATABITS  = 32,
    parameter int unsigned ADDRBITS  = 32,
    parameter int unsigned LINENUM   = 4,
    parameter int unsigned LINEWORDS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    // request side
    input  logic                   flush_req,
    input  logic [LINENUM-1:0]     flush_line_sel,
    input  logic                   flush_dirty,
    input  logic [ADDRBITS-1:0]    flush_wb_addr,
    input  logic [ADDRBITS-1:0]    flush_fill_addr,
    output logic                   flush_busy,
    output logic                   flush_done,
    // line access
    output logic [LINENUM-1:0]     flush_mode,
    output logic [$clog2(LINEWORDS)-1:0] flush_addr,
    output logic                   flush_we,
    output logic [DATABITS-1:0]    flush_in,
    input  logic [DATABITS-1:0]    line_wb_data,
    // pending CPU read forwarding
    input  logic                   pend_rdreq,
    input  logic [ADDRBITS-1:0]    pend_addr,
    output logic [DATABITS-1:0]    fwd_data,
    output logic                   fwd_valid,
    // memory controller
    output logic [ADDRBITS-1:0]    mem_addr,
    output logic [DATABITS-1:0]    mem_in,
    output logic                   mem_wrreq,
    input  logic                   mem_wr_ready,
    output logic                   mem_rdreq,
    input  logic [DATABITS-1:0]    mem_out,
    input  logic                   mem_out_valid
);

    localparam int unsigned WIDX = $clog2(LINEWORDS);
    localparam int unsigned BOFS = $clog2(DATABITS / 8);
    localparam int unsigned LOWB = WIDX + BOFS;
    localparam int unsigned TAGW = ADDRBITS - LOWB;
    localparam logic [WIDX-1:0] K_LAST = WIDX'(LINEWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_RD     = 3'd1,
        S_WB_WR     = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_DATA = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              state_q,    state_d;
    logic [WIDX-1:0]     k_q,        k_d;
    logic [LINENUM-1:0]  sel_q,      sel_d;
    logic [TAGW-1:0]     wb_tag_q,   wb_tag_d;
    logic [TAGW-1:0]     fill_tag_q, fill_tag_d;
    logic [DATABITS-1:0] hold_q,     hold_d;
    logic                wb_first_q, wb_first_d;
    logic                fwd_done_q, fwd_done_d;
    logic [DATABITS-1:0] fwd_data_q, fwd_data_d;
    logic                fwd_valid_q, fwd_valid_d;

    logic                fill_beat_c;
    logic                fwd_hit_c;
    logic [DATABITS-1:0] wb_word_c;

    // Low address bits are discarded: bases are line aligned, reads are word granular.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{flush_wb_addr[LOWB-1:0], flush_fill_addr[LOWB-1:0],
                                pend_addr[BOFS-1:0]};

    // Beat accepted from memory, and whether it is the word a queued read wants.
    assign fill_beat_c = (state_q == S_FILL_DATA) && mem_out_valid;
    assign fwd_hit_c   = fill_beat_c && pend_rdreq && !fwd_done_q
                         && (pend_addr[ADDRBITS-1:LOWB] == fill_tag_q)
                         && (pend_addr[LOWB-1:BOFS] == k_q);

    // The line's read port lags flush_addr by one cycle, so on the first
    // WB_WR cycle the word comes straight from the line, afterwards from hold.
    assign wb_word_c = wb_first_q ? line_wb_data : hold_q;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sel_d       = sel_q;
        wb_tag_d    = wb_tag_q;
        fill_tag_d  = fill_tag_q;
        hold_d      = hold_q;
        wb_first_d  = 1'b0;
        fwd_done_d  = fwd_done_q;
        fwd_data_d  = fwd_data_q;
        fwd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    sel_d      = flush_line_sel;
                    wb_tag_d   = flush_wb_addr[ADDRBITS-1:LOWB];
                    fill_tag_d = flush_fill_addr[ADDRBITS-1:LOWB];
                    k_d        = '0;
                    fwd_done_d = 1'b0;
                    state_d    = flush_dirty ? S_WB_RD : S_FILL_REQ;
                end
            end
            S_WB_RD: begin
                wb_first_d = 1'b1;
                state_d    = S_WB_WR;
            end
            S_WB_WR: begin
                if (wb_first_q) begin
                    hold_d = line_wb_data;
                end
                if (mem_wr_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_FILL_REQ;
                    end else begin
                        k_d     = k_q + WIDX'(1);
                        state_d = S_WB_RD;
                    end
                end
            end
            S_FILL_REQ: begin
                state_d = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                if (mem_out_valid) begin
                    k_d = k_q + WIDX'(1);
                    if (k_q == K_LAST) begin
                        state_d = S_DONE;
                    end
                end
                if (fwd_hit_c) begin
                    fwd_data_d  = mem_out;
                    fwd_valid_d = 1'b1;
                    fwd_done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sel_q       <= '0;
            wb_tag_q    <= '0;
            fill_tag_q  <= '0;
            hold_q      <= '0;
            wb_first_q  <= 1'b0;
            fwd_done_q  <= 1'b0;
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sel_q       <= sel_d;
            wb_tag_q    <= wb_tag_d;
            fill_tag_q  <= fill_tag_d;
            hold_q      <= hold_d;
            wb_first_q  <= wb_first_d;
            fwd_done_q  <= fwd_done_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
        end
    end

    // Output decode from registered state; fill writes pass mem_out through in the same cycle.
    always_comb begin
        flush_busy = (state_q != S_IDLE);
        flush_done = (state_q == S_DONE);
        flush_mode = (state_q != S_IDLE) ? sel_q : '0;
        flush_addr = '0;
        flush_we   = 1'b0;
        flush_in   = '0;
        mem_addr   = '0;
        mem_in     = '0;
        mem_wrreq  = 1'b0;
        mem_rdreq  = 1'b0;

        case (state_q)
            S_WB_RD: begin
                flush_addr = k_q;
            end
            S_WB_WR: begin
                flush_addr = k_q;
                mem_wrreq  = 1'b1;
                mem_addr   = {wb_tag_q, k_q, {BOFS{1'b0}}};
                mem_in     = wb_word_c;
            end
            S_FILL_REQ: begin
                mem_rdreq = 1'b1;
                mem_addr  = {fill_tag_q, {LOWB{1'b0}}};
            end
            S_FILL_DATA: begin
                flush_addr = k_q;
                if (mem_out_valid) begin
                    flush_we = 1'b1;
                    flush_in = mem_out;
                end
            end
            default: begin
            end
        endcase
    end

    assign fwd_data  = fwd_data_q;
    assign fwd_valid = fwd_valid_q;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl: clean fill with forwarding, dirty
// writeback with stalls and fill gaps, stray inputs, and reset mid-writeback.
module tb_dcache_flush_ctrl;

    logic        clk;
    logic        reset;
    logic        flush_req;
    logic [3:0]  flush_line_sel;
    logic        flush_dirty;
    logic [31:0] flush_wb_addr;
    logic [31:0] flush_fill_addr;
    logic        flush_busy;
    logic        flush_done;
    logic [3:0]  flush_mode;
    logic [4:0]  flush_addr;
    logic        flush_we;
    logic [31:0] flush_in;
    logic [31:0] line_wb_data;
    logic        pend_rdreq;
    logic [31:0] pend_addr;
    logic [31:0] fwd_data;
    logic        fwd_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_wrreq;
    logic        mem_wr_ready;
    logic        mem_rdreq;
    logic [31:0] mem_out;
    logic        mem_out_valid;

    logic [31:0] line_base;
    int          checks   = 0;
    int          failures = 0;

    dcache_flush_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .flush_req       (flush_req),
        .flush_line_sel  (flush_line_sel),
        .flush_dirty     (flush_dirty),
        .flush_wb_addr   (flush_wb_addr),
        .flush_fill_addr (flush_fill_addr),
        .flush_busy      (flush_busy),
        .flush_done      (flush_done),
        .flush_mode      (flush_mode),
        .flush_addr      (flush_addr),
        .flush_we        (flush_we),
        .flush_in        (flush_in),
        .line_wb_data    (line_wb_data),
        .pend_rdreq      (pend_rdreq),
        .pend_addr       (pend_addr),
        .fwd_data        (fwd_data),
        .fwd_valid       (fwd_valid),
        .mem_addr        (mem_addr),
        .mem_in          (mem_in),
        .mem_wrreq       (mem_wrreq),
        .mem_wr_ready    (mem_wr_ready),
        .mem_rdreq       (mem_rdreq),
        .mem_out         (mem_out),
        .mem_out_valid   (mem_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line storage model: synchronous read, word i of the line holds line_base+i.
    always @(posedge clk) line_wb_data <= line_base + 32'(flush_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush_req = 1'b0; flush_line_sel = '0; flush_dirty = 1'b0;
        flush_wb_addr = '0; flush_fill_addr = '0; pend_rdreq = 1'b0; pend_addr = '0;
        mem_wr_ready = 1'b0; mem_out = '0; mem_out_valid = 1'b0; line_base = '0;

        // Reset state
        repeat (2) cyc();
        #2;
        chk("rst_busy",  64'(flush_busy), 64'd0);
        chk("rst_mode",  64'(flush_mode), 64'd0);
        chk("rst_done",  64'(flush_done), 64'd0);
        chk("rst_wrreq", 64'(mem_wrreq),  64'd0);
        chk("rst_rdreq", 64'(mem_rdreq),  64'd0);
        chk("rst_fwdv",  64'(fwd_valid),  64'd0);
        reset = 1'b0;
        cyc();

        // Clean fill with forwarding of word 7 and a stray request mid-fill
        flush_req = 1'b1; flush_line_sel = 4'b0010; flush_dirty = 1'b0;
        flush_fill_addr = 32'h1000_0044; flush_wb_addr = 32'h5555_5555;
        pend_rdreq = 1'b1; pend_addr = 32'h1000_001C;
        cyc();
        flush_req = 1'b0;
        #2;
        chk("f1_rdreq", 64'(mem_rdreq),  64'd1);
        chk("f1_raddr", 64'(mem_addr),   64'h1000_0000);
        chk("f1_busy",  64'(flush_busy), 64'd1);
        chk("f1_mode",  64'(flush_mode), 64'h2);
        chk("f1_wrreq", 64'(mem_wrreq),  64'd0);
        cyc();
        for (int i = 0; i < 32; i++) begin
            mem_out_valid = 1'b1;
            mem_out = 32'hA000 + 32'(i);
            flush_req = (i == 10);
            #2;
            chk("f1_we",    64'(flush_we),   64'd1);
            chk("f1_addr",  64'(flush_addr), 64'(i));
            chk("f1_in",    64'(flush_in),   64'h0000_A000 + 64'(i));
            chk("f1_mode",  64'(flush_mode), 64'h2);
            chk("f1_done",  64'(flush_done), 64'd0);
            chk("f1_rdreq", 64'(mem_rdreq),  64'd0);
            chk("f1_fwdv",  64'(fwd_valid),  64'(i == 8));
            if (i == 8) chk("f1_fwdd", 64'(fwd_data), 64'h0000_A007);
            cyc();
        end
        mem_out_valid = 1'b0; flush_req = 1'b0;
        #2;
        chk("f1_done_pulse", 64'(flush_done), 64'd1);
        chk("f1_done_busy",  64'(flush_busy), 64'd1);
        chk("f1_done_we",    64'(flush_we),   64'd0);
        chk("f1_done_fwdv",  64'(fwd_valid),  64'd0);
        cyc();
        #2;
        chk("f1_idle_done", 64'(flush_done), 64'd0);
        chk("f1_idle_busy", 64'(flush_busy), 64'd0);
        chk("f1_idle_mode", 64'(flush_mode), 64'd0);
        chk("f1_fwd_hold",  64'(fwd_data),   64'h0000_A007);

        // Stray memory data while idle
        mem_out_valid = 1'b1; mem_out = 32'h0000_DEAD;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #2;
            chk("stray_busy", 64'(flush_busy), 64'd0);
            chk("stray_we",   64'(flush_we),   64'd0);
            chk("stray_done", 64'(flush_done), 64'd0);
            chk("stray_fwdv", 64'(fwd_valid),  64'd0);
        end
        mem_out_valid = 1'b0; pend_rdreq = 1'b0;

        // Dirty writeback, 3-cycle stall on word 5, then gapped fill
        line_base = 32'h0000_B000; flush_line_sel = 4'b0100; flush_dirty = 1'b1;
        flush_wb_addr = 32'h2000_0000; flush_fill_addr = 32'h3000_0000; flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int w = 0; w < 32; w++) begin
            mem_wr_ready = (w == 2);
            #2;
            chk("wb_rd_addr",  64'(flush_addr), 64'(w));
            chk("wb_rd_wrreq", 64'(mem_wrreq),  64'd0);
            chk("wb_rd_mode",  64'(flush_mode), 64'h4);
            cyc();
            for (int s = 0; s <= ((w == 5) ? 3 : 0); s++) begin
                mem_wr_ready = (s == ((w == 5) ? 3 : 0));
                #2;
                chk("wb_wrreq", 64'(mem_wrreq), 64'd1);
                chk("wb_addr",  64'(mem_addr),  64'h2000_0000 + 64'(4 * w));
                chk("wb_data",  64'(mem_in),    64'h0000_B000 + 64'(w));
                chk("wb_rdreq", 64'(mem_rdreq), 64'd0);
                cyc();
            end
        end
        mem_wr_ready = 1'b0;
        #2;
        chk("wb_fill_rdreq", 64'(mem_rdreq), 64'd1);
        chk("wb_fill_addr",  64'(mem_addr),  64'h3000_0000);
        chk("wb_fill_wrreq", 64'(mem_wrreq), 64'd0);
        cyc();
        for (int i = 0; i < 32; i++) begin
            mem_out_valid = 1'b0;
            #2;
            chk("f2_gap_we", 64'(flush_we), 64'd0);
            cyc();
            mem_out_valid = 1'b1;
            mem_out = 32'hC000 + 32'(i);
            #2;
            chk("f2_we",   64'(flush_we),   64'd1);
            chk("f2_addr", 64'(flush_addr), 64'(i));
            chk("f2_in",   64'(flush_in),   64'h0000_C000 + 64'(i));
            chk("f2_fwdv", 64'(fwd_valid),  64'd0);
            cyc();
        end
        mem_out_valid = 1'b0;
        #2;
        chk("f2_done",     64'(flush_done), 64'd1);
        chk("f2_fwd_hold", 64'(fwd_data),   64'h0000_A007);
        cyc();
        #2;
        chk("f2_idle_busy", 64'(flush_busy), 64'd0);

        // Reset in the middle of writing back word 10
        line_base = 32'h0000_D000; flush_line_sel = 4'b0001; flush_dirty = 1'b1;
        flush_wb_addr = 32'h6000_0000; flush_fill_addr = 32'h7000_0000; flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int w = 0; w < 10; w++) begin
            mem_wr_ready = 1'b0;
            cyc();
            mem_wr_ready = 1'b1;
            cyc();
        end
        mem_wr_ready = 1'b0;
        cyc();
        #2;
        chk("r_pre_wrreq", 64'(mem_wrreq), 64'd1);
        chk("r_pre_addr",  64'(mem_addr),  64'h6000_0028);
        chk("r_pre_data",  64'(mem_in),    64'h0000_D00A);
        reset = 1'b1;
        #1;
        chk("r_busy",  64'(flush_busy), 64'd0);
        chk("r_mode",  64'(flush_mode), 64'd0);
        chk("r_wrreq", 64'(mem_wrreq),  64'd0);
        chk("r_addr",  64'(mem_addr),   64'd0);
        chk("r_in",    64'(mem_in),     64'd0);
        chk("r_faddr", 64'(flush_addr), 64'd0);
        chk("r_we",    64'(flush_we),   64'd0);
        chk("r_done",  64'(flush_done), 64'd0);
        chk("r_fwdd",  64'(fwd_data),   64'd0);
        chk("r_fwdv",  64'(fwd_valid),  64'd0);
        cyc();
        reset = 1'b0;
        cyc();
        #2;
        chk("r_idle_busy", 64'(flush_busy), 64'd0);
        chk("r_idle_done", 64'(flush_done), 64'd0);

        // Clean fill after reset
        flush_line_sel = 4'b1000; flush_dirty = 1'b0; flush_fill_addr = 32'h4000_0000;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        #2;
        chk("f3_rdreq", 64'(mem_rdreq), 64'd1);
        chk("f3_raddr", 64'(mem_addr),  64'h4000_0000);
        cyc();
        for (int i = 0; i < 32; i++) begin
            mem_out_valid = 1'b1;
            mem_out = 32'hE000 + 32'(i);
            #2;
            chk("f3_we",   64'(flush_we),   64'd1);
            chk("f3_addr", 64'(flush_addr), 64'(i));
            chk("f3_in",   64'(flush_in),   64'h0000_E000 + 64'(i));
            chk("f3_mode", 64'(flush_mode), 64'h8);
            cyc();
        end
        mem_out_valid = 1'b0;
        #2;
        chk("f3_done", 64'(flush_done), 64'd1);
        cyc();
        #2;
        chk("f3_idle_busy", 64'(flush_busy), 64'd0);
        chk("f3_idle_done", 64'(flush_done), 64'd0);
        chk("f3_idle_mode", 64'(flush_mode), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
